mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Sequential load/store unit between the MEM stage and the data memory port.
- Aligns store data and generates byte enables from address and access size.
- Drives a request/grant/response handshake to a memory with variable latency.
- Extracts and sign- or zero-extends load data; flags misaligned, illegal-size and timed-out accesses.

Parameters:
- DATA_W, 32, memory data width; 32 or 64 only. NB = DATA_W/8, OFF_W = log2(NB).
- ADDR_W, 32, byte address width.
- TIMEOUT, 16, maximum cycles in WAIT before abort; 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline presents an access
- req_ready  out  1  unit accepts an access (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword
- req_signed  in  1  loads: 1 sign-extend, 0 zero-extend
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- resp_err  out  2  0 ok, 1 misaligned, 2 illegal size, 3 timeout
- busy  out  1  high in any state other than IDLE; pipeline stall
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_addr  out  ADDR_W  address with low OFF_W bits cleared
- mem_be  out  NB  byte enables
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  load data valid
- mem_rdata  in  DATA_W  raw memory word

Behaviour:
- Reset (async, reset_n=0): state IDLE. All outputs are 0 except req_ready=1. Internal latches are cleared.
- States and transitions:
  - IDLE: on req_valid & req_ready, latch we, size, signed, addr and wdata, then check the access:
    - size 3 with DATA_W=32 -> ERR, code 2.
    - addr not a multiple of 2^size -> ERR, code 1.
    - otherwise -> ISSUE.
  - ISSUE: mem_req=1 and mem signals are stable until mem_gnt.
    - On gnt, a store goes to DONE.
    - On gnt, a load goes to WAIT with the counter cleared.
  - WAIT: the counter increments each cycle.
    - On mem_rvalid, capture the extended data and go to DONE. mem_rvalid in the gnt cycle itself is ignored.
    - If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without rvalid, go to ERR with code 3.
  - DONE: resp_valid=1 and resp_err=0 for one cycle, then IDLE.
  - ERR: resp_valid=1 with the code, resp_rdata=0, for one cycle, then IDLE. No mem_req is ever issued for codes 1 and 2.
- Latency:
  - Store: 1 accept cycle + 1 or more ISSUE cycles + 1 DONE cycle. Minimum accept-to-resp_valid is 2 cycles.
  - Load: additionally at least 1 WAIT cycle.
  - Errors 1/2: resp_valid in the cycle after accept.
- Byte enables and store data:
  - off = addr[OFF_W-1:0].
  - mem_be has 2^size ones, shifted left by off.
  - mem_wdata = req_wdata << (8*off). Unused lanes are 0.
- Load extract: field = mem_rdata >> (8*off), taken to 8, 16, 32 or 64 bits.
  - Extended to DATA_W with sign if signed=1, else zeros.
  - Full-width loads ignore signed.
- Registered outputs: resp_rdata and resp_err hold their value after the pulse until the next response; resp_valid is the qualifier.
- req_ready = (state==IDLE). Requests in other states are ignored, not queued.
- mem_gnt and mem_rvalid outside ISSUE/WAIT are ignored.
- Reset mid-operation: immediate return to IDLE, mem_req drops asynchronously, no response is issued.

Test Plan:
- Byte store: DATA_W=32, addr=0x1003, size 0, wdata=0x000000AB, gnt after 2 cycles -> mem_addr=0x1000, be=4'b1000, mem_wdata=0xAB000000; resp_valid 1 cycle after gnt, err=0.
- Signed halfword load: addr=0x2002, mem_rdata=0x8001_1234, rvalid 3 cycles after gnt -> resp_rdata=0xFFFF8001. Same access with signed=0 -> 0x00008001.
- Misaligned word: addr=0x0006, size 2 -> no mem_req, resp_err=1 in the cycle after accept. Dword on DATA_W=32 -> resp_err=2.
- Timeout: TIMEOUT=4, load granted, rvalid never asserted -> resp_err=3 four cycles after entering WAIT; req_ready high in the next cycle.
- DATA_W=64 dword load at 0x...08, mem_rdata=0x0123456789ABCDEF -> resp_rdata unchanged. Signed byte load at offset 7 of 0x80... -> 0xFFFFFFFFFFFFFF80.
- Reset asserted in WAIT -> mem_req=0 and busy=0 immediately, no resp_valid. After reset_n rises, the next load completes normally.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store unit between the MEM stage and a variable-latency data memory port.
// Handles lane alignment, byte enables, load extension and access error reporting.
module mem_access_unit #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [1:0]          req_size,
  input  logic                req_signed,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                resp_valid,
  output logic [DATA_W-1:0]   resp_rdata,
  output logic [1:0]          resp_err,
  output logic                busy,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [1:0] MAX_SIZE = 2'(OFF_W);

  localparam logic [1:0] ERR_OK       = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_SIZE     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_e;

  // Handshake: an access is taken on a rising edge where req_valid && req_ready;
  // memory accepts on mem_gnt while mem_req is high; load data arrives with mem_rvalid.

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [OFF_W-1:0]  off_q, off_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [1:0]        resp_err_q, resp_err_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [NB-1:0]     mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  function automatic logic [DATA_W-1:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'd0:    size_mask = DATA_W'(8'hFF);
      2'd1:    size_mask = DATA_W'(16'hFFFF);
      2'd2:    size_mask = DATA_W'(32'hFFFF_FFFF);
      default: size_mask = '1;
    endcase
  endfunction

  function automatic logic [7:0] be_ones(input logic [1:0] sz);
    case (sz)
      2'd0:    be_ones = 8'h01;
      2'd1:    be_ones = 8'h03;
      2'd2:    be_ones = 8'h0F;
      default: be_ones = 8'hFF;
    endcase
  endfunction

  // A full-width field has an all-ones mask, so the sign fill collapses to zero.
  function automatic logic [DATA_W-1:0] extend_load(input logic [DATA_W-1:0] field,
                                                    input logic [1:0]        sz,
                                                    input logic              sgn);
    logic [DATA_W-1:0] m;
    logic              s;
    m = size_mask(sz);
    case (sz)
      2'd0:    s = field[7];
      2'd1:    s = field[15];
      2'd2:    s = field[31];
      default: s = 1'b0;
    endcase
    extend_load = (field & m) | ((sgn && s) ? ~m : '0);
  endfunction

  logic [OFF_W-1:0] req_off;
  logic [2:0]       low_mask;
  logic             misaligned;
  logic             timed_out;

  assign req_off    = req_addr[OFF_W-1:0];
  assign misaligned = |(req_addr[2:0] & low_mask);
  assign timed_out  = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    case (req_size)
      2'd0:    low_mask = 3'b000;
      2'd1:    low_mask = 3'b001;
      2'd2:    low_mask = 3'b011;
      default: low_mask = 3'b111;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    off_d        = off_q;
    cnt_d        = cnt_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_be_d     = mem_be_q;
    mem_wdata_d  = mem_wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          size_d   = req_size;
          signed_d = req_signed;
          off_d    = req_off;
          if (req_size > MAX_SIZE) begin
            state_d      = S_ERR;
            resp_err_d   = ERR_SIZE;
            resp_rdata_d = '0;
          end else if (misaligned) begin
            state_d      = S_ERR;
            resp_err_d   = ERR_MISALIGN;
            resp_rdata_d = '0;
          end else begin
            state_d     = S_ISSUE;
            mem_we_d    = req_we;
            mem_addr_d  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_be_d    = NB'(be_ones(req_size)) << req_off;
            mem_wdata_d = (req_wdata & size_mask(req_size)) << {req_off, 3'b000};
          end
        end
      end
      S_ISSUE: begin
        if (mem_gnt) begin
          if (we_q) begin
            state_d      = S_DONE;
            resp_err_d   = ERR_OK;
            resp_rdata_d = '0;
          end else begin
            state_d = S_WAIT;
            cnt_d   = '0;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid) begin
          state_d      = S_DONE;
          resp_err_d   = ERR_OK;
          resp_rdata_d = extend_load(mem_rdata >> {off_q, 3'b000}, size_q, signed_q);
        end else if (timed_out) begin
          state_d      = S_ERR;
          resp_err_d   = ERR_TIMEOUT;
          resp_rdata_d = '0;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Write strobes only mean something while the request is on the bus.
    if (state_d != S_ISSUE) begin
      mem_we_d = 1'b0;
      mem_be_d = '0;
    end
    mem_req_d    = (state_d == S_ISSUE);
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_DONE) || (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      off_q        <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 2'd0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_be_q     <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_be_q     <= mem_be_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_be     = mem_be_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a 32-bit unit with a short timeout and a 64-bit unit.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_we, a_req_signed, a_req_ready;
  logic [1:0]  a_req_size, a_resp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
  logic        a_resp_valid, a_busy, a_mem_req, a_mem_we, a_mem_gnt, a_mem_rvalid;
  logic [3:0]  a_mem_be;

  logic        b_req_valid, b_req_we, b_req_signed, b_req_ready;
  logic [1:0]  b_req_size, b_resp_err;
  logic [31:0] b_req_addr, b_mem_addr;
  logic [63:0] b_req_wdata, b_resp_rdata, b_mem_wdata, b_mem_rdata;
  logic        b_resp_valid, b_busy, b_mem_req, b_mem_we, b_mem_gnt, b_mem_rvalid;
  logic [7:0]  b_mem_be;

  mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) u_dut32 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_size(a_req_size), .req_signed(a_req_signed), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata), .resp_valid(a_resp_valid), .resp_rdata(a_resp_rdata),
    .resp_err(a_resp_err), .busy(a_busy), .mem_req(a_mem_req), .mem_we(a_mem_we),
    .mem_addr(a_mem_addr), .mem_be(a_mem_be), .mem_wdata(a_mem_wdata),
    .mem_gnt(a_mem_gnt), .mem_rvalid(a_mem_rvalid), .mem_rdata(a_mem_rdata)
  );

  mem_access_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(16)) u_dut64 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_size(b_req_size), .req_signed(b_req_signed), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
    .resp_err(b_resp_err), .busy(b_busy), .mem_req(b_mem_req), .mem_we(b_mem_we),
    .mem_addr(b_mem_addr), .mem_be(b_mem_be), .mem_wdata(b_mem_wdata),
    .mem_gnt(b_mem_gnt), .mem_rvalid(b_mem_rvalid), .mem_rdata(b_mem_rdata)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks a response pulse; the expected read data comes from exp_q.
  task automatic chk_resp(input string tag, input logic v, input logic [1:0] e,
                          input logic [63:0] d, input logic [1:0] e_exp);
    logic [63:0] d_exp;
    d_exp = 64'hBAD0_BAD0_BAD0_BAD0;
    if (exp_q.size() != 0) d_exp = exp_q.pop_front();
    chk({tag, "_valid"}, 64'(v), 64'd1);
    chk({tag, "_err"}, 64'(e), 64'(e_exp));
    chk({tag, "_rdata"}, d, d_exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic a_accept(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata);
    a_req_we = we; a_req_size = sz; a_req_signed = sgn;
    a_req_addr = addr; a_req_wdata = wdata; a_req_valid = 1'b1;
    cyc(1);
    a_req_valid = 1'b0;
  endtask

  task automatic b_accept(input logic we, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [63:0] wdata);
    b_req_we = we; b_req_size = sz; b_req_signed = sgn;
    b_req_addr = addr; b_req_wdata = wdata; b_req_valid = 1'b1;
    cyc(1);
    b_req_valid = 1'b0;
  endtask

  // 64-bit load: immediate grant, data one cycle into WAIT.
  task automatic b_load(input string tag, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [63:0] rdata,
                        input logic [31:0] addr_exp, input logic [7:0] be_exp,
                        input logic [63:0] data_exp);
    b_accept(1'b0, sz, sgn, addr, 64'd0);
    chk({tag, "_addr"}, 64'(b_mem_addr), 64'(addr_exp));
    chk({tag, "_be"}, 64'(b_mem_be), 64'(be_exp));
    b_mem_gnt = 1'b1;
    cyc(1);
    b_mem_gnt = 1'b0;
    b_mem_rvalid = 1'b1;
    b_mem_rdata = rdata;
    cyc(1);
    b_mem_rvalid = 1'b0;
    exp_q.push_back(data_exp);
    chk_resp(tag, b_resp_valid, b_resp_err, b_resp_rdata, 2'd0);
    cyc(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    a_req_valid = 0; a_req_we = 0; a_req_size = 0; a_req_signed = 0;
    a_req_addr = 0; a_req_wdata = 0; a_mem_gnt = 0; a_mem_rvalid = 0; a_mem_rdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_size = 0; b_req_signed = 0;
    b_req_addr = 0; b_req_wdata = 0; b_mem_gnt = 0; b_mem_rvalid = 0; b_mem_rdata = 0;
    cyc(2);
    chk("rst_ready", 64'(a_req_ready), 64'd1);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_mem_req", 64'(a_mem_req), 64'd0);
    chk("rst_resp_valid", 64'(a_resp_valid), 64'd0);
    chk("rst_resp_err", 64'(a_resp_err), 64'd0);
    chk("rst_rdata", 64'(a_resp_rdata), 64'd0);
    chk("rst_be", 64'(a_mem_be), 64'd0);
    chk("rst64_ready", 64'(b_req_ready), 64'd1);
    chk("rst64_mem_req", 64'(b_mem_req), 64'd0);
    reset_n = 1'b1;
    cyc(1);

    // Byte store at offset 3, grant after two ISSUE cycles; a request while busy is dropped.
    a_accept(1'b1, 2'd0, 1'b0, 32'h0000_1003, 32'h0000_00AB);
    chk("stb_mem_req", 64'(a_mem_req), 64'd1);
    chk("stb_mem_we", 64'(a_mem_we), 64'd1);
    chk("stb_addr", 64'(a_mem_addr), 64'h1000);
    chk("stb_be", 64'(a_mem_be), 64'b1000);
    chk("stb_wdata", 64'(a_mem_wdata), 64'hAB00_0000);
    chk("stb_busy", 64'(a_busy), 64'd1);
    chk("stb_ready", 64'(a_req_ready), 64'd0);
    a_req_size = 2'd3; a_req_valid = 1'b1;
    cyc(1);
    chk("stb_hold_req", 64'(a_mem_req), 64'd1);
    chk("stb_hold_addr", 64'(a_mem_addr), 64'h1000);
    a_mem_gnt = 1'b1;
    cyc(1);
    a_mem_gnt = 1'b0;
    a_req_valid = 1'b0;
    exp_q.push_back(64'd0);
    chk_resp("stb_resp", a_resp_valid, a_resp_err, 64'(a_resp_rdata), 2'd0);
    chk("stb_req_drop", 64'(a_mem_req), 64'd0);
    cyc(1);
    chk("stb_pulse_end", 64'(a_resp_valid), 64'd0);
    chk("stb_ready_back", 64'(a_req_ready), 64'd1);
    cyc(1);
    chk("stb_no_queued", 64'(a_resp_valid), 64'd0);

    // Signed halfword load, rvalid three cycles after grant.
    a_accept(1'b0, 2'd1, 1'b1, 32'h0000_2002, 32'd0);
    chk("lhs_we", 64'(a_mem_we), 64'd0);
    chk("lhs_addr", 64'(a_mem_addr), 64'h2000);
    chk("lhs_be", 64'(a_mem_be), 64'b1100);
    a_mem_gnt = 1'b1;
    cyc(1);
    a_mem_gnt = 1'b0;
    chk("lhs_wait_req", 64'(a_mem_req), 64'd0);
    chk("lhs_wait_busy", 64'(a_busy), 64'd1);
    cyc(2);
    chk("lhs_wait_novalid", 64'(a_resp_valid), 64'd0);
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h8001_1234;
    cyc(1);
    a_mem_rvalid = 1'b0;
    exp_q.push_back(64'hFFFF_8001);
    chk_resp("lhs_resp", a_resp_valid, a_resp_err, 64'(a_resp_rdata), 2'd0);
    cyc(1);
    chk("lhs_pulse_end", 64'(a_resp_valid), 64'd0);
    chk("lhs_rdata_hold", 64'(a_resp_rdata), 64'hFFFF_8001);

    // Same access unsigned; rvalid in the grant cycle carries junk and must be ignored.
    a_accept(1'b0, 2'd1, 1'b0, 32'h0000_2002, 32'd0);
    a_mem_gnt = 1'b1; a_mem_rvalid = 1'b1; a_mem_rdata = 32'hFFFF_FFFF;
    cyc(1);
    a_mem_gnt = 1'b0; a_mem_rvalid = 1'b0;
    chk("lhu_gnt_rvalid_ignored", 64'(a_resp_valid), 64'd0);
    cyc(2);
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h8001_1234;
    cyc(1);
    a_mem_rvalid = 1'b0;
    exp_q.push_back(64'h0000_8001);
    chk_resp("lhu_resp", a_resp_valid, a_resp_err, 64'(a_resp_rdata), 2'd0);
    cyc(1);

    // Misaligned word: error in the cycle after accept, no memory request.
    a_accept(1'b0, 2'd2, 1'b0, 32'h0000_0006, 32'd0);
    exp_q.push_back(64'd0);
    chk_resp("mis_resp", a_resp_valid, a_resp_err, 64'(a_resp_rdata), 2'd1);
    chk("mis_no_req", 64'(a_mem_req), 64'd0);
    cyc(1);
    chk("mis_no_req2", 64'(a_mem_req), 64'd0);
    chk("mis_ready", 64'(a_req_ready), 64'd1);
    chk("mis_err_hold", 64'(a_resp_err), 64'd1);

    // Dword on a 32-bit port is an illegal size.
    a_accept(1'b1, 2'd3, 1'b0, 32'h0000_0000, 32'h1111_2222);
    exp_q.push_back(64'd0);
    chk_resp("dw32_resp", a_resp_valid, a_resp_err, 64'(a_resp_rdata), 2'd2);
    chk("dw32_no_req", 64'(a_mem_req), 64'd0);
    cyc(1);

    // Halfword store at offset 2 with immediate grant; upper source bits are dropped.
    a_accept(1'b1, 2'd1, 1'b0, 32'h0000_0042, 32'h1234_5678);
    chk("sth_addr", 64'(a_mem_addr), 64'h40);
    chk("sth_be", 64'(a_mem_be), 64'b1100);
    chk("sth_wdata", 64'(a_mem_wdata), 64'h5678_0000);
    a_mem_gnt = 1'b1;
    cyc(1);
    a_mem_gnt = 1'b0;
    exp_q.push_back(64'd0);
    chk_resp("sth_resp", a_resp_valid, a_resp_err, 64'(a_resp_rdata), 2'd0);
    cyc(1);

    // Timeout: TIMEOUT=4, no rvalid, error four cycles after entering WAIT.
    a_accept(1'b0, 2'd2, 1'b1, 32'h0000_3000, 32'd0);
    a_mem_gnt = 1'b1;
    cyc(1);
    a_mem_gnt = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("to_wait_novalid", 64'(a_resp_valid), 64'd0);
      chk("to_wait_busy", 64'(a_busy), 64'd1);
    end
    cyc(1);
    exp_q.push_back(64'd0);
    chk_resp("to_resp", a_resp_valid, a_resp_err, 64'(a_resp_rdata), 2'd3);
    cyc(1);
    chk("to_ready", 64'(a_req_ready), 64'd1);
    chk("to_err_hold", 64'(a_resp_err), 64'd3);
    chk("to_pulse_end", 64'(a_resp_valid), 64'd0);

    // Reset while the request is on the bus drops mem_req without a clock edge.
    a_accept(1'b0, 2'd2, 1'b0, 32'h0000_0010, 32'd0);
    chk("rsti_req", 64'(a_mem_req), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rsti_req_drop", 64'(a_mem_req), 64'd0);
    chk("rsti_busy", 64'(a_busy), 64'd0);
    @(posedge clk);
    #1 reset_n = 1'b1;
    cyc(1);

    // Reset in WAIT: immediate idle, no response even with rvalid during reset.
    a_accept(1'b0, 2'd2, 1'b0, 32'h0000_0020, 32'd0);
    a_mem_gnt = 1'b1;
    cyc(1);
    a_mem_gnt = 1'b0;
    cyc(1);
    chk("rstw_busy_pre", 64'(a_busy), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstw_busy", 64'(a_busy), 64'd0);
    chk("rstw_req", 64'(a_mem_req), 64'd0);
    chk("rstw_ready", 64'(a_req_ready), 64'd1);
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    chk("rstw_no_resp", 64'(a_resp_valid), 64'd0);
    a_mem_rvalid = 1'b0;
    reset_n = 1'b1;
    cyc(1);
    chk("rstw_no_resp2", 64'(a_resp_valid), 64'd0);
    chk("rstw_err_clr", 64'(a_resp_err), 64'd0);

    // First load after reset: unsigned byte at offset 1.
    a_accept(1'b0, 2'd0, 1'b0, 32'h0000_4001, 32'd0);
    chk("lbu_be", 64'(a_mem_be), 64'b0010);
    a_mem_gnt = 1'b1;
    cyc(1);
    a_mem_gnt = 1'b0;
    a_mem_rvalid = 1'b1; a_mem_rdata = 32'h1122_3344;
    cyc(1);
    a_mem_rvalid = 1'b0;
    exp_q.push_back(64'h33);
    chk_resp("lbu_resp", a_resp_valid, a_resp_err, 64'(a_resp_rdata), 2'd0);
    cyc(1);

    // 64-bit unit.
    b_load("ld64", 2'd3, 1'b1, 32'h0000_1008, 64'h0123_4567_89AB_CDEF,
           32'h0000_1008, 8'hFF, 64'h0123_4567_89AB_CDEF);
    b_load("lb64s", 2'd0, 1'b1, 32'h0000_1007, 64'h8000_0000_0000_0000,
           32'h0000_1000, 8'h80, 64'hFFFF_FFFF_FFFF_FF80);
    b_load("lw64s", 2'd2, 1'b1, 32'h0000_2004, 64'h8765_4321_0000_0000,
           32'h0000_2000, 8'hF0, 64'hFFFF_FFFF_8765_4321);
    b_load("lw64u", 2'd2, 1'b0, 32'h0000_2004, 64'h8765_4321_0000_0000,
           32'h0000_2000, 8'hF0, 64'h0000_0000_8765_4321);

    b_accept(1'b1, 2'd2, 1'b0, 32'h0000_0104, 64'hFFFF_FFFF_DEAD_BEEF);
    chk("sw64_addr", 64'(b_mem_addr), 64'h100);
    chk("sw64_be", 64'(b_mem_be), 64'hF0);
    chk("sw64_wdata", b_mem_wdata, 64'hDEAD_BEEF_0000_0000);
    b_mem_gnt = 1'b1;
    cyc(1);
    b_mem_gnt = 1'b0;
    exp_q.push_back(64'd0);
    chk_resp("sw64_resp", b_resp_valid, b_resp_err, b_resp_rdata, 2'd0);
    cyc(1);

    b_accept(1'b0, 2'd3, 1'b0, 32'h0000_1004, 64'd0);
    exp_q.push_back(64'd0);
    chk_resp("mis64_resp", b_resp_valid, b_resp_err, b_resp_rdata, 2'd1);
    chk("mis64_no_req", 64'(b_mem_req), 64'd0);
    cyc(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
